signed_mac_accumulator: RTL and testbench

SIGNED_MAC_ACCUMULATOR -- requirements
Module: signed_mac_accumulator

---
 rtl/mac_pkg.sv | 16 +
 rtl/sat_add64.sv | 25 ++
 rtl/signed_mac_accumulator.sv | 90 +++++++++
 tb/tb_signed_mac_accumulator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the signed multiply-accumulate block.
// Saturation limits are consumed by sat_add64 when MAC_SATURATE_EN is defined.
package mac_pkg;

  localparam int ACC_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/sat_add64.sv
// Combinational 64-bit signed adder with overflow detect.
// With MAC_SATURATE_EN defined the sum clamps to the signed limits on overflow; otherwise it wraps.
module sat_add64
  import mac_pkg::*;
(
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] raw;

  assign raw = a + b;

  // Overflow only possible when operands share a sign and the result flips it.
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef MAC_SATURATE_EN
  assign sum = ovf ? (a[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/signed_mac_accumulator.sv
// Signed 64-bit accumulator of multiplier product terms with valid/ready in and out.
// Build option MAC_SATURATE_EN (in sat_add64) selects clamping instead of wrapping on overflow.
module signed_mac_accumulator
  import mac_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] product,
  input  logic                    in_last,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic [COUNT_W-1:0]      term_count,
  output logic                    overflow
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_t                  state;
  state_t                  state_next;
  logic signed [ACC_W-1:0] acc;
  logic [COUNT_W-1:0]      count;
  logic                    ovf_flag;
  logic                    accept;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;

  assign in_ready   = (state != HOLD);
  assign out_valid  = (state == HOLD);
  // abort outranks the input handshake, so a term offered alongside it is dropped.
  assign accept     = in_valid && in_ready && !abort;
  assign acc_out    = acc;
  assign term_count = count;
  assign overflow   = ovf_flag;

  sat_add64 u_add (
    .a   (acc),
    .b   (product),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = in_last ? HOLD : ACCUM;
        ACCUM:   if (accept && in_last) state_next = HOLD;
        HOLD:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // First term of a burst loads; later terms add and keep the overflow flag sticky.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      acc      <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc      <= product;
        count    <= COUNT_ONE;
        ovf_flag <= 1'b0;
      end else begin
        acc      <= sum;
        count    <= (count == COUNT_MAX) ? count : count + COUNT_ONE;
        ovf_flag <= ovf_flag | add_ovf;
      end
    end
  end

endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Self-checking bench for signed_mac_accumulator: directed cases plus randomized bursts.
// Expected results come from a wide-integer reference model; honours MAC_SATURATE_EN.
module tb_signed_mac_accumulator;

  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic signed [65:0] LIM_HI = (66'sd1 <<< 63) - 66'sd1;
  localparam logic signed [65:0] LIM_LO = -(66'sd1 <<< 63);
  localparam logic [63:0] POS_CLAMP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_CLAMP = 64'h8000_0000_0000_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [63:0] product;
  logic               in_last;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic signed [63:0] acc_out;
  logic [CW-1:0]      term_count;
  logic               overflow;

  int tests = 0;
  int fails = 0;

  logic signed [63:0] model_acc;
  int                 model_cnt;
  logic               model_ovf;
  logic               model_open;

  signed_mac_accumulator #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .product    (product),
    .in_last    (in_last),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .term_count (term_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic signed [63:0] p, input logic last,
                                input logic ab);
    in_valid = v;
    product  = p;
    in_last  = last;
    abort    = ab;
  endtask

  task automatic model_reset();
    model_acc  = '0;
    model_cnt  = 0;
    model_ovf  = 1'b0;
    model_open = 1'b0;
  endtask

  // Exact sum in 66 bits; anything outside the 64-bit signed range is an overflow.
  task automatic model_term(input logic signed [63:0] p, input logic last);
    logic signed [65:0] wide;
    if (!model_open) begin
      model_acc = p;
      model_cnt = 1;
      model_ovf = 1'b0;
    end else begin
      wide = model_acc;
      wide = wide + p;
      if (wide > LIM_HI || wide < LIM_LO) begin
        model_ovf = 1'b1;
`ifdef MAC_SATURATE_EN
        model_acc = (wide > LIM_HI) ? POS_CLAMP : NEG_CLAMP;
`else
        model_acc = wide[63:0];
`endif
      end else begin
        model_acc = wide[63:0];
      end
      if (model_cnt < CNT_MAX) model_cnt++;
    end
    model_open = !last;
  endtask

  task automatic send_term(input logic signed [63:0] p, input logic last);
    apply_stimulus(1'b1, p, last, 1'b0);
    check_output("in_ready_offer", {63'd0, in_ready}, 64'd1);
    tick();
    model_term(p, last);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_result(input string tag);
    check_output({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_output({tag, "_acc"}, acc_out, model_acc);
    check_output({tag, "_cnt"}, {{(64-CW){1'b0}}, term_count}, 64'(model_cnt));
    check_output({tag, "_ovf"}, {63'd0, overflow}, {63'd0, model_ovf});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    check_output("drain_idle", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic signed [63:0] held;
    logic [63:0]        r;
    int                 n;
    logic signed [63:0] p;

    rst = 1'b1;
    out_ready = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    tick();
    tick();
    check_output("rst_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_acc", acc_out, 64'd0);
    check_output("rst_cnt", {{(64-CW){1'b0}}, term_count}, 64'd0);
    check_output("rst_ovf", {63'd0, overflow}, 64'd0);
    rst = 1'b0;
    tick();
    check_output("rst_ready", {63'd0, in_ready}, 64'd1);

    // Small mixed-sign burst, result on the cycle after the last accept.
    out_ready = 1'b1;
    send_term(64'sd6, 1'b0);
    send_term(-64'sd20, 1'b0);
    check_output("sum3_not_yet", {63'd0, out_valid}, 64'd0);
    send_term(64'sd100, 1'b1);
    check_output("sum3_const", acc_out, 64'd86);
    check_result("sum3");
    tick();
    check_output("sum3_idle", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    // Single large negative term, then stall in HOLD.
    send_term(-64'sh3FFF_FFFF_0000_0001, 1'b1);
    check_output("single_const", acc_out, -64'sh3FFF_FFFF_0000_0001);
    check_result("single");
    held = acc_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("stall_ready", {63'd0, in_ready}, 64'd0);
      check_output("stall_valid", {63'd0, out_valid}, 64'd1);
      check_output("stall_acc", acc_out, held);
    end
    drain();
    check_output("stall_ready_after", {63'd0, in_ready}, 64'd1);

    // Positive overflow.
    send_term(POS_CLAMP, 1'b0);
    send_term(64'sd1, 1'b1);
    check_output("ovf_flag", {63'd0, overflow}, 64'd1);
`ifdef MAC_SATURATE_EN
    check_output("ovf_acc", acc_out, POS_CLAMP);
`else
    check_output("ovf_acc", acc_out, NEG_CLAMP);
`endif
    check_result("ovf");
    drain();

    // Abort with a term offered mid-accumulation.
    send_term(64'sd40, 1'b0);
    send_term(64'sd2, 1'b0);
    apply_stimulus(1'b1, 64'sd5, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    check_output("abort_valid", {63'd0, out_valid}, 64'd0);
    check_output("abort_acc", acc_out, 64'd0);
    check_output("abort_cnt", {{(64-CW){1'b0}}, term_count}, 64'd0);
    check_output("abort_ovf", {63'd0, overflow}, 64'd0);
    send_term(64'sd7, 1'b1);
    check_result("after_abort");
    // Abort in HOLD drops the pending result.
    apply_stimulus(1'b1, 64'sd9, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    check_output("abort_hold_valid", {63'd0, out_valid}, 64'd0);
    check_output("abort_hold_acc", acc_out, 64'd0);

    // Reset while holding a result.
    send_term(64'sd3, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_output("rsthold_valid", {63'd0, out_valid}, 64'd0);
    check_output("rsthold_acc", acc_out, 64'd0);
    check_output("rsthold_cnt", {{(64-CW){1'b0}}, term_count}, 64'd0);
    check_output("rsthold_ovf", {63'd0, overflow}, 64'd0);
    send_term(64'sd11, 1'b0);
    send_term(64'sd22, 1'b1);
    check_output("rsthold_new_acc", acc_out, 64'd33);
    check_result("rsthold_new");
    drain();

    // Count saturates while the sum keeps growing.
    for (int i = 0; i < 18; i++) send_term(64'sd1, (i == 17));
    check_output("cntsat_cnt", {{(64-CW){1'b0}}, term_count}, 64'(CNT_MAX));
    check_output("cntsat_acc", acc_out, 64'd18);
    check_result("cntsat");
    drain();

    // Randomized bursts with gaps and output stalls.
    for (int pkt = 0; pkt < 12; pkt++) begin
      n = $urandom_range(1, 20);
      for (int t = 0; t < n; t++) begin
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       p = {{48{r[15]}}, r[15:0]};
          1:       p = r;
          2:       p = {2'b01, r[61:0]};
          default: p = {2'b10, r[61:0]};
        endcase
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        send_term(p, (t == n - 1));
      end
      check_result("rand");
      held = acc_out;
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        tick();
        check_output("rand_stall_acc", acc_out, held);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
